// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table, blank
// pattern, dp bit position and nibble pack/unpack helpers.
package seven_seg_pkg;

   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam int         DP_BIT     = 7;
   localparam int         MAX_DIGITS = 32;

   // Active-low {dp,g,f,e,d,c,b,a}, dp off
   localparam logic [7:0] GLYPH_TBL [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [3:0] get_nibble(input logic [4*MAX_DIGITS-1:0] vec, input int i);
      return vec[4*i +: 4];
   endfunction

   function automatic logic [4*MAX_DIGITS-1:0] put_nibble(input logic [4*MAX_DIGITS-1:0] vec,
                                                          input int i, input logic [3:0] nib);
      logic [4*MAX_DIGITS-1:0] v;
      v = vec;
      v[4*i +: 4] = nib;
      return v;
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
module seg_glyph_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_dp,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg         = GLYPH_TBL[i_nib];
      o_seg[DP_BIT] = ~i_dp;
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment controller with shadowed data,
// per-digit dp/enable. Define SEG_LZB_EN to add leading-zero blanking.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter  int N_DIGITS = 8,
   parameter  int SCAN_DIV = 100000,
   localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
   localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [4*N_DIGITS-1:0] i_num,
   input  logic [N_DIGITS-1:0]   i_point,
   input  logic [N_DIGITS-1:0]   i_en,
   output logic [7:0]            o_seg,
   output logic [N_DIGITS-1:0]   o_an,
   output logic [IDX_W-1:0]      o_digit
);

   logic [DIV_W-1:0]        r_div_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*N_DIGITS-1:0]   r_num;
   logic [N_DIGITS-1:0]     r_point;
   logic [N_DIGITS-1:0]     r_en;
   logic [7:0]              r_seg;
   logic [N_DIGITS-1:0]     r_an;
   logic [IDX_W-1:0]        r_digit;

   logic [4*MAX_DIGITS-1:0] w_num_ext;
   logic [3:0]              w_nib;
   logic                    w_dp;
   logic [7:0]              w_glyph;
   logic                    w_show;
   logic [N_DIGITS-1:0]     w_blank_lzb;
   logic [N_DIGITS-1:0]     w_an_sel;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div_cnt <= '0;
         r_idx     <= '0;
      end else if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
         r_div_cnt <= '0;
         r_idx     <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_num   <= '0;
         r_point <= '0;
         r_en    <= '0;
      end else if (i_load) begin
         r_num   <= i_num;
         r_point <= i_point;
         r_en    <= i_en;
      end
   end

`ifdef SEG_LZB_EN
   // Mask is built from the incoming data so it lands in the same edge as the shadow
   logic [4*MAX_DIGITS-1:0] w_in_ext;
   logic [N_DIGITS-1:0]     w_lzb_next;
   logic [N_DIGITS-1:0]     r_lzb;
   logic                    w_seen;

   always_comb begin
      w_in_ext                 = '0;
      w_in_ext[4*N_DIGITS-1:0] = i_num;
   end

   always_comb begin
      w_seen     = 1'b0;
      w_lzb_next = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (i_en[i] && (get_nibble(w_in_ext, i) != 4'h0))
            w_seen = 1'b1;
         w_lzb_next[i] = i_en[i] && !w_seen && !i_point[i] && (get_nibble(w_in_ext, i) == 4'h0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_lzb <= '0;
      else if (i_load)
         r_lzb <= w_lzb_next;
   end

   assign w_blank_lzb = r_lzb;
`else
   assign w_blank_lzb = '0;
`endif

   always_comb begin
      w_num_ext                 = '0;
      w_num_ext[4*N_DIGITS-1:0] = r_num;
   end

   assign w_nib    = get_nibble(w_num_ext, int'(r_idx));
   assign w_dp     = r_point[r_idx];
   assign w_show   = r_en[r_idx] & ~w_blank_lzb[r_idx];
   assign w_an_sel = ~(N_DIGITS'(1) << r_idx);

   seg_glyph_decode u_dec (
      .i_nib (w_nib),
      .i_dp  (w_dp),
      .o_seg (w_glyph)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_seg   <= SEG_OFF;
         r_an    <= '1;
         r_digit <= '0;
      end else begin
         r_seg   <= w_show ? w_glyph : SEG_OFF;
         r_an    <= w_show ? w_an_sel : '1;
         r_digit <= r_idx;
      end
   end

   assign o_seg   = r_seg;
   assign o_an    = r_an;
   assign o_digit = r_digit;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: per-edge expectations from a time-based display model,
// checked by an independent negedge monitor.
module tb_seven_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int SD = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] num   = '0;
   logic [3:0]  point = '0;
   logic [3:0]  en    = '0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic [1:0]  digit;

   seven_seg_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_load  (load),
      .i_num   (num),
      .i_point (point),
      .i_en    (en),
      .o_seg   (seg),
      .o_an    (an),
      .o_digit (digit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] an;
      logic [1:0] digit;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [7:0] glyph [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Model: shadow contents and edges elapsed since the last reset edge
   int          m_t   = 0;
   logic [15:0] m_num = '0;
   logic [3:0]  m_pt  = '0;
   logic [3:0]  m_en  = '0;

   function automatic bit lzb(input int i);
`ifdef SEG_LZB_EN
      int v;
      v = 0;
      for (int j = 0; j < N; j++)
         if (m_en[j]) v += int'(m_num[4*j +: 4]) << (4*j);
      return (i > 0) && m_en[i] && !m_pt[i] && ((v >> (4*i)) == 0);
`else
      return (i < 0);
`endif
   endfunction

   task automatic step(input bit r, input bit l, input logic [15:0] n,
                       input logic [3:0] p, input logic [3:0] e);
      exp_t        x;
      int          idx;
      logic [3:0]  one;
      @(negedge clk);
      rst = r; load = l; num = n; point = p; en = e;
      @(posedge clk);
      one = 4'b0001;
      if (r) begin
         x.seg = 8'hFF; x.an = 4'hF; x.digit = 2'd0;
      end else begin
         idx     = (m_t / SD) % N;
         x.digit = 2'(idx);
         if (m_en[idx] && !lzb(idx)) begin
            x.seg = glyph[m_num[4*idx +: 4]];
            if (m_pt[idx]) x.seg[7] = 1'b0;
            x.an  = ~(one << idx);
         end else begin
            x.seg = 8'hFF; x.an = 4'hF;
         end
      end
      sb.push_back(x);
      if (r) begin
         m_t = 0; m_num = '0; m_pt = '0; m_en = '0;
      end else begin
         m_t++;
         if (l) begin m_num = n; m_pt = p; m_en = e; end
      end
   endtask

   task automatic idle(input int k);
      repeat (k) step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   always @(negedge clk) begin : monitor
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         checks++;
         if (seg !== x.seg) begin
            errors++;
            $display("FAIL seg t=%0t got %h want %h", $time, seg, x.seg);
         end
         checks++;
         if (an !== x.an) begin
            errors++;
            $display("FAIL an t=%0t got %b want %b", $time, an, x.an);
         end
         checks++;
         if (digit !== x.digit) begin
            errors++;
            $display("FAIL digit t=%0t got %0d want %0d", $time, digit, x.digit);
         end
      end
   end

   initial begin
      // Reset held, then release with empty shadow
      repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(6);
      // Plain digits
      step(1'b0, 1'b1, 16'h1234, 4'b0000, 4'hF);
      idle(20);
      // Decimal point on digit 1
      step(1'b0, 1'b1, 16'hABCD, 4'b0010, 4'hF);
      idle(16);
      // Enable mask
      step(1'b0, 1'b1, 16'hABCD, 4'b0000, 4'b0101);
      idle(16);
      // Leading zeros (blanked only when the option is built in)
      step(1'b0, 1'b1, 16'h0070, 4'b0000, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'h0000, 4'b0000, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'h0005, 4'b0100, 4'b1101);
      idle(16);
      // Mid-scan reset at idx 2 with load held during reset
      step(1'b0, 1'b1, 16'h9876, 4'hF, 4'hF);
      for (int k = 0; k < 32 && ((m_t / SD) % N) != 2; k++) idle(1);
      step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF);
      step(1'b1, 1'b1, 16'h1111, 4'hF, 4'hF);
      idle(12);
      // Random traffic, including loads on advance edges and sporadic resets
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
              16'($urandom), 4'($urandom), 4'($urandom));
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
